// File: rtl/bin_frame_streamer_if.sv
// Stream port bundle for the bin frame streamer: one word per beat with
// valid/ready handshake and an end-of-frame marker.
interface bin_frame_streamer_if #(
  parameter int N = 16
) ();
  logic [N-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/bin_frame_streamer.sv
// Output stage after the N-bin averager. Buffers averaged frames in two slots
// (ACTIVE, PENDING) and streams each frame one bin per beat, optionally
// prefixed by a header beat carrying the frame sequence number.
module bin_frame_streamer #(
  parameter int BINS   = 4,
  parameter int N      = 16,
  parameter int HDR_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic [BINS-1:0][N-1:0]   in_data,
  input  logic                     in_valid,
  bin_frame_streamer_if.master     m,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     busy
);

  localparam int KW = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BINS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic [KW-1:0]            k, k_n;
  logic [N-1:0]             tdata_r, tdata_n;
  logic                     tvalid_r, tvalid_n;
  logic                     tlast_r, tlast_n;
  logic [CNT_W-1:0]         frame_cnt_n, drop_cnt_n;
  logic [BINS-1:0][N-1:0]   act_data, act_data_n;
  logic [BINS-1:0][N-1:0]   pend_data, pend_data_n;
  logic                     pend_full, pend_full_n;
  logic                     act_full;
  logic                     hs, last_hs, act_avail, pend_avail, start;

  // Header word: frame counter zero-extended or truncated to the stream width.
  function automatic logic [N-1:0] hdr_word(input logic [CNT_W-1:0] c);
    logic [N+CNT_W-1:0] ext;
    ext = {{N{1'b0}}, c};
    return ext[N-1:0];
  endfunction

  // The ACTIVE slot is occupied exactly while a frame is being sequenced.
  assign act_full = (state != ST_IDLE);
  assign busy     = act_full || pend_full;

  assign m.m_tdata  = tdata_r;
  assign m.m_tvalid = tvalid_r;
  assign m.m_tlast  = tlast_r;

  // Slot bookkeeping, drop accounting and beat sequencing for the next cycle.
  always_comb begin
    state_n     = state;
    k_n         = k;
    tdata_n     = tdata_r;
    tvalid_n    = tvalid_r;
    tlast_n     = tlast_r;
    frame_cnt_n = frame_cnt;
    drop_cnt_n  = drop_cnt;
    act_data_n  = act_data;
    pend_data_n = pend_data;
    pend_full_n = pend_full;
    start       = 1'b0;

    hs      = tvalid_r && m.m_tready;
    last_hs = hs && tlast_r;
    // A final handshake frees ACTIVE, but a waiting PENDING frame takes it over,
    // which in turn frees PENDING for a frame arriving in the same cycle.
    act_avail  = !act_full || (last_hs && !pend_full);
    pend_avail = !pend_full || last_hs;

    if (last_hs) begin
      pend_full_n = 1'b0;
      if (pend_full) begin
        act_data_n = pend_data;
      end
    end

    if (in_valid) begin
      if (act_avail) begin
        act_data_n = in_data;
      end else if (pend_avail) begin
        pend_data_n = in_data;
        pend_full_n = 1'b1;
      end else if (drop_cnt != {CNT_W{1'b1}}) begin
        drop_cnt_n = drop_cnt + CNT_W'(1);
      end
    end

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          start = 1'b1;
        end
      end
      ST_HDR: begin
        if (hs) begin
          state_n = ST_DATA;
          k_n     = '0;
          tdata_n = act_data[0];
          tlast_n = (BINS == 1);
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (tlast_r) begin
            frame_cnt_n = frame_cnt + CNT_W'(1);
            if (pend_full || in_valid) begin
              start = 1'b1;
            end else begin
              state_n  = ST_IDLE;
              tvalid_n = 1'b0;
              tlast_n  = 1'b0;
              tdata_n  = '0;
            end
          end else begin
            k_n     = k + KW'(1);
            tdata_n = act_data[k_n];
            tlast_n = (k_n == K_LAST);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Launch a frame from whatever lands in ACTIVE this cycle, with no bubble.
    if (start) begin
      state_n  = (HDR_EN != 0) ? ST_HDR : ST_DATA;
      k_n      = '0;
      tvalid_n = 1'b1;
      tdata_n  = (HDR_EN != 0) ? hdr_word(frame_cnt_n) : act_data_n[0];
      tlast_n  = (HDR_EN != 0) ? 1'b0 : (BINS == 1);
    end
  end

  // Control state, registered stream outputs and counters.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      tdata_r   <= '0;
      tvalid_r  <= 1'b0;
      tlast_r   <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      pend_full <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      tdata_r   <= tdata_n;
      tvalid_r  <= tvalid_n;
      tlast_r   <= tlast_n;
      frame_cnt <= frame_cnt_n;
      drop_cnt  <= drop_cnt_n;
      pend_full <= pend_full_n;
    end
  end

  // Frame slot contents; occupancy flags qualify them, so no reset is needed.
  always_ff @(posedge clk) begin
    act_data  <= act_data_n;
    pend_data <= pend_data_n;
  end

endmodule

// File: tb/tb_bin_frame_streamer.sv
// Scoreboard bench for bin_frame_streamer: one instance with header beats,
// one without; expected beats are queued when frames are offered and popped
// as the stream handshakes them.
module tb_bin_frame_streamer;
  localparam int BINS  = 4;
  localparam int N     = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   areset_n;
  logic [BINS-1:0][N-1:0] a_in_data, b_in_data;
  logic                   a_in_valid, b_in_valid;
  logic [CNT_W-1:0]       a_frame_cnt, a_drop_cnt, b_frame_cnt, b_drop_cnt;
  logic                   a_busy, b_busy;

  bin_frame_streamer_if #(.N(N)) sa ();
  bin_frame_streamer_if #(.N(N)) sb ();

  bin_frame_streamer #(.BINS(BINS), .N(N), .HDR_EN(1), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .areset_n(areset_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .m(sa), .frame_cnt(a_frame_cnt), .drop_cnt(a_drop_cnt), .busy(a_busy)
  );

  bin_frame_streamer #(.BINS(BINS), .N(N), .HDR_EN(0), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .areset_n(areset_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .m(sb), .frame_cnt(b_frame_cnt), .drop_cnt(b_drop_cnt), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [N:0] qa[$];
  logic [N:0] qb[$];
  int acc_a = 0;
  bit toggle_a = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_a) sa.m_tready = ~sa.m_tready;
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    acc_a = 0;
  endtask

  task automatic do_reset();
    areset_n   = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    clear_model();
    tick();
    areset_n = 1'b1;
  endtask

  task automatic send_a(input logic [N-1:0] b0, b1, b2, b3, input bit dropped);
    a_in_data  = {b3, b2, b1, b0};
    a_in_valid = 1'b1;
    if (!dropped) begin
      qa.push_back({1'b0, N'(acc_a)});
      qa.push_back({1'b0, b0});
      qa.push_back({1'b0, b1});
      qa.push_back({1'b0, b2});
      qa.push_back({1'b1, b3});
      acc_a++;
    end
    tick();
    a_in_valid = 1'b0;
    a_in_data  = {$urandom, $urandom};
  endtask

  task automatic send_b(input logic [N-1:0] b0, b1, b2, b3);
    b_in_data  = {b3, b2, b1, b0};
    b_in_valid = 1'b1;
    qb.push_back({1'b0, b0});
    qb.push_back({1'b0, b1});
    qb.push_back({1'b0, b2});
    qb.push_back({1'b1, b3});
    tick();
    b_in_valid = 1'b0;
    b_in_data  = {$urandom, $urandom};
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((a_busy || b_busy || qa.size() != 0 || qb.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drain_in_time"}, 32'(n < 300), 1);
    check({tag, "_qa_empty"}, qa.size(), 0);
    check({tag, "_qb_empty"}, qb.size(), 0);
  endtask

  // Stream monitors: compare handshaken beats against the queues and check stall stability.
  logic       a_stall = 1'b0, b_stall = 1'b0;
  logic [N:0] a_prev, b_prev;

  always @(negedge clk) begin
    logic [N:0] e;
    if (areset_n) begin
      if (a_stall) begin
        check("a_hold_valid", sa.m_tvalid, 1);
        check("a_hold_word", {sa.m_tlast, sa.m_tdata}, a_prev);
      end
      if (sa.m_tvalid && sa.m_tready) begin
        if (qa.size() == 0) check("a_unexpected_beat", sa.m_tvalid, 0);
        else begin
          e = qa.pop_front();
          check("a_beat", {sa.m_tlast, sa.m_tdata}, e);
        end
      end
      a_stall = sa.m_tvalid && !sa.m_tready;
      a_prev  = {sa.m_tlast, sa.m_tdata};
    end else a_stall = 1'b0;
  end

  always @(negedge clk) begin
    logic [N:0] e;
    if (areset_n) begin
      if (b_stall) begin
        check("b_hold_valid", sb.m_tvalid, 1);
        check("b_hold_word", {sb.m_tlast, sb.m_tdata}, b_prev);
      end
      if (sb.m_tvalid && sb.m_tready) begin
        if (qb.size() == 0) check("b_unexpected_beat", sb.m_tvalid, 0);
        else begin
          e = qb.pop_front();
          check("b_beat", {sb.m_tlast, sb.m_tdata}, e);
        end
      end
      b_stall = sb.m_tvalid && !sb.m_tready;
      b_prev  = {sb.m_tlast, sb.m_tdata};
    end else b_stall = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset_n    = 1'b0;
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_in_data   = '0;
    b_in_data   = '0;
    sa.m_tready = 1'b1;
    sb.m_tready = 1'b1;
    tick();
    do_reset();

    // Reset state
    check("rst_tvalid", sa.m_tvalid, 0);
    check("rst_tlast", sa.m_tlast, 0);
    check("rst_tdata", sa.m_tdata, 0);
    check("rst_busy", a_busy, 0);
    check("rst_frame_cnt", a_frame_cnt, 0);
    check("rst_drop_cnt", a_drop_cnt, 0);

    // 1: single frame, always ready
    send_a(10, 11, 12, 13, 0);
    check("t1_latency_valid", sa.m_tvalid, 1);
    check("t1_first_word_hdr", sa.m_tdata, 0);
    wait_drain("t1");
    check("t1_frame_cnt", a_frame_cnt, 1);

    // 2: alternating ready
    do_reset();
    toggle_a = 1'b1;
    send_a(10, 11, 12, 13, 0);
    wait_drain("t2");
    toggle_a    = 1'b0;
    sa.m_tready = 1'b1;
    check("t2_frame_cnt", a_frame_cnt, 1);
    check("t2_drop_cnt", a_drop_cnt, 0);

    // 3: overflow drops the third frame
    do_reset();
    sa.m_tready = 1'b0;
    send_a(10, 11, 12, 13, 0);
    send_a(5, 6, 7, 8, 0);
    send_a(15, 16, 17, 18, 1);
    check("t3_drop_cnt", a_drop_cnt, 1);
    check("t3_busy", a_busy, 1);
    sa.m_tready = 1'b1;
    wait_drain("t3");
    check("t3_frame_cnt", a_frame_cnt, 2);
    check("t3_drop_cnt_end", a_drop_cnt, 1);

    // 4: new frame in the cycle of the tlast handshake with PENDING full
    do_reset();
    sa.m_tready = 1'b0;
    send_a(1, 2, 3, 4, 0);
    send_a(21, 22, 23, 24, 0);
    sa.m_tready = 1'b1;
    n = 0;
    while (!sa.m_tlast && n < 20) begin
      tick();
      n++;
    end
    check("t4_tlast_seen", sa.m_tlast, 1);
    send_a(31, 32, 33, 34, 0);
    wait_drain("t4");
    check("t4_drop_cnt", a_drop_cnt, 0);
    check("t4_frame_cnt", a_frame_cnt, 3);

    // 5: reset mid-frame with PENDING full
    do_reset();
    sa.m_tready = 1'b0;
    send_a(10, 11, 12, 13, 0);
    send_a(5, 6, 7, 8, 0);
    sa.m_tready = 1'b1;
    tick();
    tick();
    tick();
    sa.m_tready = 1'b0;
    check("t5_mid_beat", sa.m_tdata, 12);
    areset_n = 1'b0;
    clear_model();
    tick();
    check("t5_tvalid", sa.m_tvalid, 0);
    check("t5_tlast", sa.m_tlast, 0);
    check("t5_tdata", sa.m_tdata, 0);
    check("t5_busy", a_busy, 0);
    check("t5_frame_cnt", a_frame_cnt, 0);
    check("t5_drop_cnt", a_drop_cnt, 0);
    areset_n    = 1'b1;
    sa.m_tready = 1'b1;
    send_a(40, 41, 42, 43, 0);
    check("t5_hdr_after_reset", sa.m_tdata, 0);
    wait_drain("t5");
    check("t5_frame_cnt_end", a_frame_cnt, 1);

    // 6: no header, back-to-back frames with no idle cycles
    do_reset();
    sb.m_tready = 1'b1;
    send_b(100, 101, 102, 103);
    check("t6_valid_0", sb.m_tvalid, 1);
    send_b(200, 201, 202, 203);
    for (int i = 1; i < 8; i++) begin
      check("t6_valid_run", sb.m_tvalid, 1);
      tick();
    end
    check("t6_valid_end", sb.m_tvalid, 0);
    wait_drain("t6");
    check("t6_frame_cnt", b_frame_cnt, 2);
    check("t6_drop_cnt", b_drop_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
